// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan states and segment constants for the display mux
package display_pkg;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [1:0] ANODE_OFF  = 2'b11;
  localparam logic [1:0] ANODE_DIG0 = 2'b10;
  localparam logic [1:0] ANODE_DIG1 = 2'b01;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; active-low so a lit segment is a 0
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - two-digit multiplexed seven-segment scan with dead time
module display_mux_scheduler
  import display_pkg::*;
#(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] s,
  output logic [6:0] seg,
  output logic [1:0] anode,
  output logic       toggle
);

  localparam int CW = $clog2(max_int(SHOW_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    nib0, nib0_nx;
  logic [3:0]    nib1, nib1_nx;
  logic [3:0]    dec_in;
  logic [6:0]    dec_out;
  logic [6:0]    seg_nx;
  logic [1:0]    anode_nx;
  logic          toggle_nx;

  // Decode the nibble that will be on display after this edge, so seg is a flop
  seven_seg_decoder u_decoder (
    .nibble (dec_in),
    .seg    (dec_out)
  );

  // Next state, dwell count, nibble capture and the registered output values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    nib0_nx  = nib0;
    nib1_nx  = nib1;
    if (!enable) begin
      state_nx = BLANK0;
      cnt_nx   = '0;
    end else begin
      case (state)
        BLANK0: if (cnt == BLANK_LAST) begin
          state_nx = SHOW0;
          cnt_nx   = '0;
          nib0_nx  = s[3:0];
        end
        SHOW0: if (cnt == SHOW_LAST) begin
          state_nx = BLANK1;
          cnt_nx   = '0;
        end
        BLANK1: if (cnt == BLANK_LAST) begin
          state_nx = SHOW1;
          cnt_nx   = '0;
          nib1_nx  = s[7:4];
        end
        SHOW1: if (cnt == SHOW_LAST) begin
          state_nx = BLANK0;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = BLANK0;
          cnt_nx   = '0;
        end
      endcase
    end

    dec_in    = (state_nx == SHOW1) ? nib1_nx : nib0_nx;
    seg_nx    = SEG_BLANK;
    anode_nx  = ANODE_OFF;
    toggle_nx = (state_nx == BLANK1) || (state_nx == SHOW1);
    case (state_nx)
      SHOW0: begin
        seg_nx   = dec_out;
        anode_nx = ANODE_DIG0;
      end
      SHOW1: begin
        seg_nx   = dec_out;
        anode_nx = ANODE_DIG1;
      end
      default: begin
        seg_nx   = SEG_BLANK;
        anode_nx = ANODE_OFF;
      end
    endcase
  end

  // State, counter, captured digits and glitch-free output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BLANK0;
      cnt    <= '0;
      nib0   <= 4'h0;
      nib1   <= 4'h0;
      seg    <= SEG_BLANK;
      anode  <= ANODE_OFF;
      toggle <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      nib0   <= nib0_nx;
      nib1   <= nib1_nx;
      seg    <= seg_nx;
      anode  <= anode_nx;
      toggle <= toggle_nx;
    end
  end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - self-checking bench for display_mux_scheduler
module tb_display_mux_scheduler;

  localparam int SHOW   = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = 2 * (SHOW + BLANK);

  localparam logic [6:0] BL    = 7'b1111111;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] s = 8'h00;
  logic [6:0] seg;
  logic [1:0] anode;
  logic       toggle;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position since the last restart, plus captured digits
  int         m_pos = 0;
  logic [3:0] m_nib0 = 4'h0;
  logic [3:0] m_nib1 = 4'h0;
  logic [6:0] e_seg;
  logic [1:0] e_anode;
  logic       e_toggle;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] sv;
    logic [6:0] seg;
    logic [1:0] an;
    logic       tg;
  } vec_t;

  vec_t vt[$];

  display_mux_scheduler #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .s      (s),
    .seg    (seg),
    .anode  (anode),
    .toggle (toggle)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_edge();
    int r;
    if (reset) begin
      m_pos  = 0;
      m_nib0 = 4'h0;
      m_nib1 = 4'h0;
    end else if (!enable) begin
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
      r = m_pos % PERIOD;
      if (r == BLANK) m_nib0 = s[3:0];
      if (r == 2 * BLANK + SHOW) m_nib1 = s[7:4];
    end
  endtask

  task automatic model_out();
    int r;
    r = m_pos % PERIOD;
    if (r < BLANK) begin
      e_seg = BL; e_anode = 2'b11; e_toggle = 1'b0;
    end else if (r < BLANK + SHOW) begin
      e_seg = seg_of(m_nib0); e_anode = 2'b10; e_toggle = 1'b0;
    end else if (r < 2 * BLANK + SHOW) begin
      e_seg = BL; e_anode = 2'b11; e_toggle = 1'b1;
    end else begin
      e_seg = seg_of(m_nib1); e_anode = 2'b01; e_toggle = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_out();
    chk("model_seg", seg, e_seg);
    chk("model_anode", anode, e_anode);
    chk("model_toggle", toggle, e_toggle);
    chk("anode_not_both_low", (anode == 2'b00), 0);
  endtask

  task automatic do_reset(input logic [7:0] sv);
    s = sv;
    enable = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic r, input logic e, input logic [7:0] sv,
                      input logic [6:0] sg, input logic [1:0] an, input logic tg);
    vec_t v;
    v.rst = r; v.en = e; v.sv = sv; v.seg = sg; v.an = an; v.tg = tg;
    vt.push_back(v);
  endtask

  initial begin
    // Reset for 3 cycles, then one full scan period with s=8'h3A
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 8'h3A, BL, 2'b11, 1'b0);
    push(1'b0, 1'b1, 8'h3A, BL, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'h3A, SEG_A, 2'b10, 1'b0);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 8'h3A, BL, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'h3A, SEG_3, 2'b01, 1'b1);
    push(1'b0, 1'b1, 8'h3A, BL, 2'b11, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst;
      enable = vt[i].en;
      s = vt[i].sv;
      step();
      chk("vec_seg", seg, vt[i].seg);
      chk("vec_anode", anode, vt[i].an);
      chk("vec_toggle", toggle, vt[i].tg);
    end

    // s changes mid-SHOW0: held digit stays until the next capture
    do_reset(8'h3A);
    steps(3);
    s = 8'h55;
    steps(2);
    chk("midshow_hold_seg", seg, SEG_A);
    steps(9);
    chk("next_show0_seg", seg, SEG_5);
    chk("next_show0_anode", anode, 2'b10);

    // enable dropped during SHOW1, then restored
    do_reset(8'h3A);
    steps(9);
    enable = 1'b0;
    step();
    chk("en_low_seg", seg, BL);
    chk("en_low_anode", anode, 2'b11);
    chk("en_low_toggle", toggle, 1'b0);
    enable = 1'b1;
    step();
    chk("en_rise_blank_anode", anode, 2'b11);
    step();
    chk("en_rise_show_anode", anode, 2'b10);
    chk("en_rise_show_seg", seg, SEG_A);

    // reset pulsed mid-SHOW0
    do_reset(8'h3A);
    steps(4);
    reset = 1'b1;
    step();
    chk("mid_reset_seg", seg, BL);
    chk("mid_reset_anode", anode, 2'b11);
    chk("mid_reset_toggle", toggle, 1'b0);
    reset = 1'b0;
    step();
    chk("post_reset_c1_anode", anode, 2'b11);
    step();
    chk("post_reset_c2_anode", anode, 2'b10);
    chk("post_reset_c2_seg", seg, SEG_A);

    // Decode sweep of digit 0
    for (int v = 0; v < 16; v++) begin
      do_reset({4'h0, 4'(v)});
      steps(2);
      chk("sweep_anode", anode, 2'b10);
      chk("sweep_seg", seg, seg_of(4'(v)));
    end

    // Randomized run against the model
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      enable = ($urandom_range(29) != 0);
      if ($urandom_range(3) == 0) s = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
